// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC sequencing, instruction memory requests and the IF/ID register,
// with a one-entry hold buffer that catches a word returned while decode is stalled.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm,
  output logic [25:0] id_jaddr
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_instr_q, hold_instr_d, hold_pc_q, hold_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d, id_pc_plus4_q, id_pc_plus4_d, id_instr_q, id_instr_d;
  assign imem_req    = state_q == FETCH;
  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_instr    = id_instr_q;
  assign id_opcode   = id_instr_q[31:26];
  assign id_rs       = id_instr_q[25:21];
  assign id_rt       = id_instr_q[20:16];
  assign id_rd       = id_instr_q[15:11];
  assign id_shamt    = id_instr_q[10:6];
  assign id_funct    = id_instr_q[5:0];
  assign id_imm      = id_instr_q[15:0];
  assign id_jaddr    = id_instr_q[25:0];
  // The hold buffer is full exactly when the FSM sits in HOLD, so no separate flag is kept.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    id_valid_d    = stall ? id_valid_q : 1'b0;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_instr_d    = id_instr_q;
    if (redirect) begin
      state_d    = FETCH;
      pc_d       = {redirect_pc[31:2], 2'b00};
      id_valid_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = FETCH;
    end else if (state_q == FETCH && imem_ack) begin
      pc_d = pc_q + 32'd4;
      if (!stall || !id_valid_q) begin
        id_valid_d    = 1'b1;
        id_pc_d       = pc_q;
        id_pc_plus4_d = pc_q + 32'd4;
        id_instr_d    = imem_rdata;
      end else begin
        hold_instr_d = imem_rdata;
        hold_pc_d    = pc_q;
        state_d      = HOLD;
      end
    end else if (state_q == HOLD && !stall) begin
      id_valid_d    = 1'b1;
      id_pc_d       = hold_pc_q;
      id_pc_plus4_d = hold_pc_q + 32'd4;
      id_instr_d    = hold_instr_q;
      state_d       = FETCH;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_instr_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_instr_q    <= id_instr_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed vector table for the fetch stage plus hand-written
// sequences for asynchronous reset in HOLD and PC wrap-around.
module tb_instruction_fetch_stage;
  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_pc, id_pc_plus4, id_instr;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [15:0] id_imm;
  logic [25:0] id_jaddr;
  logic        w_rst_n = 1'b0, w_stall = 1'b0, w_redirect = 1'b0, w_ack = 1'b1;
  logic [31:0] w_redirect_pc = '0, w_rdata = 32'h1234_5678;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_pc4, w_instr;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm;
  logic [25:0] w_jaddr;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  instruction_fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_funct(id_funct), .id_imm(id_imm), .id_jaddr(id_jaddr)
  );
  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .id_valid(w_valid), .id_pc(w_pc), .id_pc_plus4(w_pc4), .id_instr(w_instr),
    .id_opcode(w_opcode), .id_rs(w_rs), .id_rt(w_rt), .id_rd(w_rd), .id_shamt(w_shamt),
    .id_funct(w_funct), .id_imm(w_imm), .id_jaddr(w_jaddr)
  );
  typedef struct packed {
    logic        stall, redirect;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_pc4, e_instr;
  } vec_t;
  vec_t vec [17];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_id(input string tag, input logic req, input logic [31:0] addr, input logic v,
                        input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] instr);
    chk({tag, " imem_req"}, 32'(imem_req), 32'(req));
    chk({tag, " imem_addr"}, imem_addr, addr);
    chk({tag, " id_valid"}, 32'(id_valid), 32'(v));
    chk({tag, " id_pc"}, id_pc, pc);
    chk({tag, " id_pc_plus4"}, id_pc_plus4, pc4);
    chk({tag, " id_instr"}, id_instr, instr);
  endtask
  initial begin
    vec[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h5555_5555, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0,   32'h0};
    vec[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hA000_0000, 1'b1, 32'h4,   1'b1, 32'h0,   32'h4,   32'hA000_0000};
    vec[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hA000_0004, 1'b1, 32'h8,   1'b1, 32'h4,   32'h8,   32'hA000_0004};
    vec[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hA000_0008, 1'b0, 32'hC,   1'b1, 32'h4,   32'h8,   32'hA000_0004};
    vec[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 32'hC,   1'b1, 32'h4,   32'h8,   32'hA000_0004};
    vec[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hFFFF_FFFF, 1'b0, 32'hC,   1'b1, 32'h4,   32'h8,   32'hA000_0004};
    vec[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 32'hC,   1'b1, 32'h8,   32'hC,   32'hA000_0008};
    vec[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hA000_000C, 1'b1, 32'h10,  1'b1, 32'hC,   32'h10,  32'hA000_000C};
    vec[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 32'h10,  1'b0, 32'hC,   32'h10,  32'hA000_000C};
    vec[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h2108_FFFF, 1'b1, 32'h14,  1'b1, 32'h10,  32'h14,  32'h2108_FFFF};
    vec[10] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 32'h14,  1'b1, 32'h10,  32'h14,  32'h2108_FFFF};
    vec[11] = '{1'b1, 1'b1, 32'h103, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h100, 1'b0, 32'h10,  32'h14,  32'h2108_FFFF};
    vec[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hA000_0100, 1'b1, 32'h104, 1'b1, 32'h100, 32'h104, 32'hA000_0100};
    vec[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1111_1111, 1'b0, 32'h108, 1'b1, 32'h100, 32'h104, 32'hA000_0100};
    vec[14] = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h0,         1'b1, 32'h200, 1'b0, 32'h100, 32'h104, 32'hA000_0100};
    vec[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hA000_0200, 1'b1, 32'h204, 1'b1, 32'h200, 32'h204, 32'hA000_0200};
    vec[16] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hA000_0204, 1'b0, 32'h208, 1'b1, 32'h200, 32'h204, 32'hA000_0200};
    #12;
    chk_id("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      stall = vec[i].stall; redirect = vec[i].redirect; redirect_pc = vec[i].rpc;
      imem_ack = vec[i].ack; imem_rdata = vec[i].rdata;
      @(posedge clk); #1;
      chk_id($sformatf("vec%0d", i), vec[i].e_req, vec[i].e_addr, vec[i].e_valid,
             vec[i].e_pc, vec[i].e_pc4, vec[i].e_instr);
      chk($sformatf("vec%0d opcode", i), 32'(id_opcode), 32'(vec[i].e_instr[31:26]));
      chk($sformatf("vec%0d jaddr", i), 32'(id_jaddr), 32'(vec[i].e_instr[25:0]));
      if (i == 9) begin
        chk("split opcode", 32'(id_opcode), 32'h08);
        chk("split rs", 32'(id_rs), 32'd8);
        chk("split rt", 32'(id_rt), 32'd8);
        chk("split rd", 32'(id_rd), 32'h1F);
        chk("split shamt", 32'(id_shamt), 32'h1F);
        chk("split funct", 32'(id_funct), 32'h3F);
        chk("split imm", 32'(id_imm), 32'hFFFF);
        chk("split jaddr", 32'(id_jaddr), 32'h108_FFFF);
      end
    end
    stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_id("async reset in HOLD", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hA000_0000;
    @(posedge clk); #1;
    chk_id("post reset idle", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk_id("post reset fetch", 1'b1, 32'h4, 1'b1, 32'h0, 32'h4, 32'hA000_0000);
    @(negedge clk);
    w_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("wrap req", 32'(w_req), 32'h1);
    chk("wrap addr0", w_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap id_pc0", w_pc, 32'hFFFF_FFFC);
    chk("wrap pc4_0", w_pc4, 32'h0);
    chk("wrap addr1", w_addr, 32'h0);
    chk("wrap valid", 32'(w_valid), 32'h1);
    @(posedge clk); #1;
    chk("wrap id_pc1", w_pc, 32'h0);
    chk("wrap pc4_1", w_pc4, 32'h4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (bits [1:0] SHALL be 00).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port stall, input, 1, decode stage cannot accept a new instruction this cycle.
REQ-005 The block SHALL have port redirect, input, 1, branch/jump taken; restart fetch at redirect_pc.
REQ-006 The block SHALL have port redirect_pc, input, 32, new fetch address.
REQ-007 The block SHALL have port imem_req, output, 1, instruction memory request.
REQ-008 The block SHALL have port imem_addr, output, 32, fetch address, held stable while imem_req=1 and imem_ack=0.
REQ-009 The block SHALL have port imem_ack, input, 1, imem_rdata valid for the current imem_addr this cycle.
REQ-010 The block SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-011 The block SHALL have ports id_valid (1), id_pc (32), id_pc_plus4 (32) and id_instr (32), all outputs, forming the IF/ID register.
REQ-012 The block SHALL have outputs id_opcode (6), id_rs (5), id_rt (5), id_rd (5), id_shamt (5), id_funct (6), id_imm (16) and id_jaddr (26), the combinational field split of id_instr.

Function
REQ-013 Field split SHALL be: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0], jaddr=[25:0]; id_imm feeds the immediate extender unchanged.
REQ-014 State machine SHALL have states IDLE, FETCH and HOLD.
REQ-015 In IDLE, imem_req SHALL be 0; the next cycle SHALL enter FETCH unconditionally.
REQ-016 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal the PC register.
REQ-017 FETCH with imem_ack=1 and (stall=0 or id_valid=0): id_instr<=imem_rdata, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4; remain in FETCH (back-to-back fetch, 1 instruction per cycle at zero-wait memory).
REQ-018 FETCH with imem_ack=1, stall=1 and id_valid=1: imem_rdata and pc SHALL be captured into a one-entry hold buffer, pc<=pc+4, state<=HOLD; the ID register SHALL be unchanged.
REQ-019 In HOLD, imem_req SHALL be 0; when stall=0, the hold buffer SHALL load into the ID register (id_valid<=1) and state<=FETCH; while stall=1, everything SHALL hold.
REQ-020 When stall=0 and no new instruction loads the ID register, id_valid SHALL clear to 0 (instruction consumed); when stall=1, all id_* registers SHALL hold.
REQ-021 redirect=1 SHALL take priority over every other event in the same cycle: pc<={redirect_pc[31:2],2'b00}, id_valid<=0, hold buffer discarded, state<=FETCH.
REQ-022 An imem_ack arriving in the redirect cycle SHALL be discarded; a pending request is abandoned and the address change starts a new request.
REQ-023 redirect with stall=1 SHALL still clear id_valid (flush overrides stall).
REQ-024 PC arithmetic SHALL be modulo 2^32: pc=32'hFFFF_FFFC increments to 32'h0000_0000, and id_pc_plus4 wraps identically.
REQ-025 imem_req SHALL never be 1 while the hold buffer is full; at most one instruction SHALL be buffered beyond the ID register.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, imem_req=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0 and hold buffer empty, regardless of clk.
REQ-027 Reset asserted mid-request or in HOLD SHALL discard the in-flight or held instruction; after release, the first imem_req SHALL occur in the second rising edge's cycle (IDLE then FETCH) with imem_addr=RESET_PC.

Verification
REQ-028 Reset release, imem_ack tied 1, rdata=addr-derived pattern -> imem_addr 0,4,8,...; id_pc 0,4,8 on consecutive cycles; id_valid=1 continuously.
REQ-029 Instruction 32'h2108_FFFF delivered -> id_opcode=6'h08, id_rs=8, id_rt=8, id_imm=16'hFFFF, id_rd=5'h1F, id_funct=6'h3F.
REQ-030 stall=1 for 3 cycles while ack arrives for pc=8 -> ID holds pc=4, state HOLD, imem_req=0; on stall release ID shows pc=8 next cycle, then fetch resumes at 12, nothing lost or duplicated.
REQ-031 redirect=1, redirect_pc=32'h0000_0103 with simultaneous ack and stall=1 -> next cycle id_valid=0, imem_addr=32'h0000_0100, acked word dropped.
REQ-032 RESET_PC=32'hFFFF_FFFC, ack tied 1 -> id_pc FFFF_FFFC with id_pc_plus4=0, then id_pc=0.
REQ-033 rst_n pulsed low asynchronously between edges while in HOLD -> outputs zero immediately; after release, refetch starts at RESET_PC.
